clkdiv_ctrl: RTL and testbench
==============================

# clkdiv_ctrl

Programmable clock divider with a run-time reconfiguration controller. It generates a 50%-duty divided output `clock_out` from `clock_in`, plus a one-cycle `tick` strobe that downstream logic uses as a clock enable. New divide ratios arrive over a valid/ready handshake. The controller defers each new ratio to the next full-period boundary, so `clock_out` never produces a runt pulse. It sits between board-level control logic and every block that consumes the divided clock or tick.

## Interface
Parameters:
- `WIDTH`, 16: width of the half-period count and config value.
- `DEFAULT_HALF`, 4: half-period in `clock_in` cycles loaded at reset. Must be ≥ 1.

Ports:
- `clock_in`, input, 1: the single clock; all logic is on its rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `en`, input, 1: run enable. Low holds the divider stopped and `clock_out` at 0.
- `cfg_valid`, input, 1: a new half-period is offered.
- `cfg_half`, input, WIDTH: the requested half-period in `clock_in` cycles.
- `cfg_ready`, output, 1: the controller can accept a config (state IDLE).
- `cfg_done`, output, 1: one-cycle pulse when the new ratio becomes active.
- `cfg_err`, output, 1: one-cycle pulse when a config of zero is rejected.
- `active_half`, output, WIDTH: the half-period currently in effect.
- `clock_out`, output, 1: the registered divided clock. Period is 2·`active_half` cycles.
- `tick`, output, 1: registered one-cycle pulse coincident with each 0→1 transition of `clock_out`.

## Operation
- The counter `cnt` runs 0..`active_half`-1 while `en`=1.
  - When `cnt`=`active_half`-1: `cnt`←0 and `clock_out` toggles.
  - Otherwise `cnt` increments.
- Period boundary: the cycle where `cnt`=`active_half`-1, `clock_out`=1 and `en`=1, i.e. `clock_out` is about to fall.
- Controller states:
  - IDLE: `cfg_ready`=1.
  - PENDING: `cfg_ready`=0; holds the `pend_half` register.
- IDLE with `cfg_valid`=1 and `cfg_half`≠0: capture `pend_half`, go to PENDING.
- IDLE with `cfg_valid`=1 and `cfg_half`=0: pulse `cfg_err` on the next cycle. State, ratio and counter are unchanged.
- PENDING at a period boundary:
  - `active_half`←`pend_half`, `cnt`←0, `clock_out`←0.
  - Pulse `cfg_done` next cycle; go to IDLE.
  - The new ratio starts with a full low phase.
- PENDING with `en`=0: apply on the next cycle, without waiting for a boundary. Same updates and `cfg_done` pulse as above.
- `en`=0 in any state: `cnt`←0 and `clock_out`←0, taking effect from the next edge. No `tick`.
- `en` 0→1: `cnt` starts at 0 with `clock_out`=0. The first rise comes `active_half` cycles later.
- A config accepted in the same cycle as a boundary is applied at the following boundary, not the current one.
- A `cfg_valid` held high after acceptance is ignored until `cfg_ready` reasserts. Every acceptance is a separate transaction.
- `active_half`=1 gives a divide-by-2 output that toggles every cycle. `tick` is then high every other cycle.

## Timing
- Reset (`reset_n`=0 at a rising edge) sets:
  - `clock_out`=0, `tick`=0, `cnt`=0;
  - `active_half`=DEFAULT_HALF;
  - state IDLE, so `cfg_ready`=1;
  - `cfg_done`=0, `cfg_err`=0.
- Reset mid-PENDING discards `pend_half`. `active_half` returns to DEFAULT_HALF, not the pending value.
- `cfg_ready` is combinational from state and falls the cycle after acceptance.
- `cfg_done` and `cfg_err` last exactly one cycle.
- `tick` is asserted in the same cycle that the registered `clock_out` first reads 1.
- Worst-case config latency, from acceptance to `cfg_done`: 2·`active_half`(old)+1 cycles.
- All arithmetic is unsigned WIDTH bits. `cnt` never exceeds `active_half`-1, so no wrap is possible.

## Test plan
- Reset, then `en`=1 with DEFAULT_HALF=4 → `clock_out` is 0 for 4 cycles, then 1 for 4 cycles (period 8). `tick` pulses once per period. `active_half`=4.
- `cfg_half`=2 accepted mid-high-phase → `cfg_ready` drops next cycle. At the boundary `clock_out` falls, then runs with period 4. `cfg_done` pulses once and `active_half` reads 2 in the same cycle. No high phase shorter than 2 cycles.
- `cfg_half`=0 offered → `cfg_err` pulses one cycle. `cfg_ready` stays 1 and the period is unchanged at 8.
- `cfg_half`=1 accepted, then `en` dropped while PENDING → applied next cycle with a `cfg_done` pulse. On `en`=1, `clock_out` toggles every cycle.
- `reset_n` asserted while PENDING with `cfg_half`=7 → `active_half`=4, `cfg_ready`=1, `clock_out`=0. No `cfg_done` follows.
- Config offered exactly on a boundary cycle → the current boundary keeps the old ratio. The new ratio applies one full period later, with `cfg_done` accordingly.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - programmable 50% clock divider with boundary-aligned ratio reconfiguration
// New half-periods are held pending until clock_out is about to fall, or applied at once while stopped.
module clkdiv_ctrl #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_HALF = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [WIDTH-1:0] active_half,
  output logic             clock_out,
  output logic             tick
);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last_cnt;
  logic             boundary;

  assign last_cnt = (cnt_q == active_q - WIDTH'(1));
  assign boundary = en && last_cnt && clk_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (!en) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (last_cnt) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_half != '0) begin
            pend_d  = cfg_half;
            state_d = PENDING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PENDING: begin
        // Switching only as clock_out falls guarantees the new ratio starts with a full low phase.
        if (!en || boundary) begin
          active_d = pend_q;
          cnt_d    = '0;
          clk_d    = 1'b0;
          tick_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= WIDTH'(DEFAULT_HALF);
      pend_q   <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign active_half = active_q;
  assign clock_out   = clk_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - scoreboard bench for clkdiv_ctrl
// A cycle model predicts every output; directed counters check period, latency and pulse counts.
module tb_clkdiv_ctrl;

  localparam int W = 16;

  logic         clock_in;
  logic         reset_n;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_err;
  logic [W-1:0] active_half;
  logic         clock_out;
  logic         tick;

  clkdiv_ctrl #(.WIDTH(W), .DEFAULT_HALF(4)) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_half    (cfg_half),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .active_half (active_half),
    .clock_out   (clock_out),
    .tick        (tick)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  typedef struct {
    logic         co;
    logic         tk;
    logic         done;
    logic         err;
    logic         rdy;
    logic [W-1:0] act;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // model state
  int   m_cnt, m_act, m_pend;
  logic m_co, m_pnd;

  // directed observation counters
  int n_tick, n_done, n_err, n_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic predict();
    exp_t e;
    int   n_cnt, n_act, n_pend;
    logic n_co, n_pnd, n_tk, n_done, n_err, wrap;
    n_cnt = m_cnt; n_act = m_act; n_pend = m_pend; n_co = m_co; n_pnd = m_pnd;
    n_tk = 1'b0; n_done = 1'b0; n_err = 1'b0;
    if (!reset_n) begin
      n_cnt = 0; n_act = 4; n_pend = 0; n_co = 1'b0; n_pnd = 1'b0;
    end else begin
      wrap = (m_cnt + 1 == m_act);
      if (m_pnd && (!en || (wrap && m_co))) begin
        n_act = m_pend; n_cnt = 0; n_co = 1'b0; n_done = 1'b1; n_pnd = 1'b0;
      end else if (!en) begin
        n_cnt = 0; n_co = 1'b0;
      end else if (wrap) begin
        n_cnt = 0; n_co = !m_co; n_tk = !m_co;
      end else begin
        n_cnt = m_cnt + 1;
      end
      if (!m_pnd && cfg_valid) begin
        if (cfg_half == '0) n_err = 1'b1;
        else begin
          n_pend = int'(cfg_half); n_pnd = 1'b1;
        end
      end
    end
    m_cnt = n_cnt; m_act = n_act; m_pend = n_pend; m_co = n_co; m_pnd = n_pnd;
    e.co = n_co; e.tk = n_tk; e.done = n_done; e.err = n_err;
    e.rdy = !n_pnd; e.act = W'(n_act);
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    predict();
    @(posedge clock_in);
    #1;
    e = sb.pop_front();
    chk("clock_out",   32'(clock_out),   32'(e.co));
    chk("tick",        32'(tick),        32'(e.tk));
    chk("cfg_done",    32'(cfg_done),    32'(e.done));
    chk("cfg_err",     32'(cfg_err),     32'(e.err));
    chk("cfg_ready",   32'(cfg_ready),   32'(e.rdy));
    chk("active_half", 32'(active_half), 32'(e.act));
    n_tick += int'(tick);
    n_done += int'(cfg_done);
    n_err  += int'(cfg_err);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr();
    n_tick = 0; n_done = 0; n_err = 0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    m_cnt = 0; m_act = 4; m_pend = 0; m_co = 1'b0; m_pnd = 1'b0;
    clr();
    run(2);
    chk("reset_active", 32'(active_half), 32'd4);
    chk("reset_ready",  32'(cfg_ready),   32'd1);
    chk("reset_clk",    32'(clock_out),   32'd0);
    reset_n = 1'b1;
    run(1);

    // default ratio: period 8, one tick per period
    en = 1'b1;
    clr();
    run(3);
    chk("first_low_phase", 32'(clock_out), 32'd0);
    run(1);
    chk("first_rise", 32'(clock_out), 32'd1);
    run(16);
    chk("ticks_default", 32'(n_tick), 32'd3);

    // half=2 accepted mid-high phase
    clr();
    cfg_half = 16'd2; cfg_valid = 1'b1;
    run(1);
    cfg_valid = 1'b0;
    chk("ready_drop", 32'(cfg_ready), 32'd0);
    run(12);
    chk("done_once_h2", 32'(n_done), 32'd1);
    chk("active_h2",    32'(active_half), 32'd2);
    clr();
    run(16);
    chk("ticks_h2", 32'(n_tick), 32'd4);

    // zero config rejected
    clr();
    cfg_half = 16'd0; cfg_valid = 1'b1;
    run(1);
    cfg_valid = 1'b0;
    run(8);
    chk("err_once",     32'(n_err),       32'd1);
    chk("err_no_done",  32'(n_done),      32'd0);
    chk("active_kept",  32'(active_half), 32'd2);

    // half=1 accepted, then applied immediately while stopped
    clr();
    cfg_half = 16'd1; cfg_valid = 1'b1;
    run(1);
    cfg_valid = 1'b0; en = 1'b0;
    run(3);
    chk("done_stopped",  32'(n_done),      32'd1);
    chk("active_h1",     32'(active_half), 32'd1);
    en = 1'b1;
    clr();
    run(8);
    chk("ticks_div2", 32'(n_tick), 32'd4);

    // reset while pending discards the pending ratio
    cfg_half = 16'd7; cfg_valid = 1'b1;
    run(1);
    cfg_valid = 1'b0;
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    chk("rst_pend_active", 32'(active_half), 32'd4);
    chk("rst_pend_ready",  32'(cfg_ready),   32'd1);
    chk("rst_pend_clk",    32'(clock_out),   32'd0);
    clr();
    run(20);
    chk("rst_pend_nodone", 32'(n_done), 32'd0);

    // config offered on a boundary cycle: applied one full period later
    en = 1'b0;
    run(1);
    en = 1'b1;
    run(7);
    cfg_half = 16'd3; cfg_valid = 1'b1;
    run(1);
    cfg_valid = 1'b0;
    chk("bnd_old_kept", 32'(active_half), 32'd4);
    clr();
    n_cyc = 0;
    while (n_done == 0 && n_cyc < 30) begin
      cycle();
      n_cyc++;
    end
    chk("bnd_latency", 32'(n_cyc),       32'd8);
    chk("bnd_active",  32'(active_half), 32'd3);
    run(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
